// File: rtl/output_rr_sched.sv
// Four-input round-robin scheduler feeding one registered output slot.
// Define OUTPUT_RR_SCHED_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module output_rr_sched #(
    parameter int WIDTH_packet = 57,
    parameter int NUM_IN       = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
    output logic [NUM_IN-1:0]              in_ready,
    output logic                           out_valid,
    output logic [WIDTH_packet-1:0]        out_data,
    input  logic                           out_ready,
    output logic [1:0]                     grant_id
`ifdef OUTPUT_RR_SCHED_STATS_EN
    ,
    output logic [NUM_IN*16-1:0]           grant_cnt
`endif
);

    // Handshake rule on every channel: a transfer happens exactly in a cycle
    // where valid and ready are both 1; valid never waits on ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] ptr_q;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       reg_free;
    logic       accept;

    assign out_valid = (state_q == FULL);

    // Search ptr+1, ptr+2, ptr+3, ptr; 2-bit arithmetic gives the wrap for free.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && in_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        reg_free = !out_valid || out_ready;
        accept   = reg_free && found && !reset;
        in_ready = '0;
        if (accept) begin
            in_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ptr resets to 3 so that requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            grant_id <= '0;
            ptr_q    <= 2'd3;
        end else if (accept) begin
            out_data <= in_data[int'(winner)*WIDTH_packet +: WIDTH_packet];
            grant_id <= winner;
            ptr_q    <= winner;
        end
    end

`ifdef OUTPUT_RR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
        end else if (accept && grant_cnt[int'(winner)*16 +: 16] != 16'hFFFF) begin
            grant_cnt[int'(winner)*16 +: 16] <= grant_cnt[int'(winner)*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_output_rr_sched.sv
// Self-checking bench for output_rr_sched: directed scenarios plus randomized traffic
// against a round-robin reference model and an expected-packet queue.
module tb_output_rr_sched;

    localparam int W = 57;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [1:0]     grant_id;
`ifdef OUTPUT_RR_SCHED_STATS_EN
    logic [63:0]    grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic           m_valid;
    logic [W-1:0]   m_data;
    logic [1:0]     m_grant;
    logic [1:0]     m_ptr;
    int             m_cnt[4];
    logic           acc;
    logic [3:0]     exp_ready;
    logic [3:0]     obs_ready;
    logic [W+1:0]   exp_q[$];

    output_rr_sched #(.WIDTH_packet(W), .NUM_IN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id)
`ifdef OUTPUT_RR_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Next requester after p (cyclically, p itself last) with its valid set; -1 if none.
    function automatic int pick(input logic [3:0] v, input logic [1:0] p);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(p) + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [4*W-1:0] rand_data();
        logic [4*W-1:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic do_reset(input logic [3:0] v);
        reset     = 1'b1;
        in_valid  = v;
        in_data   = rand_data();
        out_ready = 1'b1;
        #1;
        obs_ready = in_ready;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_grant = 2'd0;
        m_ptr   = 2'd3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        exp_q.delete();
    endtask

    // Applies one cycle of inputs; samples in_ready before the edge, outputs 1 time unit after.
    task automatic drive(input logic [3:0] v, input logic [4*W-1:0] d, input logic orr);
        int w;
        in_valid  = v;
        in_data   = d;
        out_ready = orr;
        #1;
        obs_ready = in_ready;
        w         = pick(v, m_ptr);
        exp_ready = '0;
        acc       = 1'b0;
        if ((!m_valid || orr) && w >= 0) begin
            exp_ready[w] = 1'b1;
            acc          = 1'b1;
        end
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_data  = d[w*W +: W];
            m_grant = 2'(w);
            m_ptr   = 2'(w);
            if (m_cnt[w] < 65535) m_cnt[w]++;
            exp_q.push_back({m_grant, m_data});
        end else if (m_valid && orr) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset(4'b1111);
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready got %b exp 0000", obs_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || grant_id !== 2'd0) begin
            errors++; $display("FAIL reset_outputs got v=%b d=%h g=%0d exp 0/0/0", out_valid, out_data, grant_id);
        end
    endtask

    task automatic test_rr_all();
        logic [4*W-1:0] d;
        int seq[5] = '{0, 1, 2, 3, 0};
        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) begin
            d = rand_data();
            drive(4'b1111, d, 1'b1);
            checks++;
            if (obs_ready !== (4'b0001 << seq[i])) begin
                errors++; $display("FAIL rr_all_ready[%0d] got %b exp onehot %0d", i, obs_ready, seq[i]);
            end
            checks++;
            if (out_valid !== 1'b1 || grant_id !== 2'(seq[i]) || out_data !== d[seq[i]*W +: W]) begin
                errors++; $display("FAIL rr_all_out[%0d] got v=%b g=%0d exp v=1 g=%0d", i, out_valid, grant_id, seq[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [4*W-1:0] d;
        do_reset(4'b0000);
        d = rand_data();
        d[2*W +: W] = 57'h0AB;
        drive(4'b0100, d, 1'b1);
        checks++;
        if (obs_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready got %b exp 0100", obs_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 57'h0AB || grant_id !== 2'd2) begin
            errors++; $display("FAIL single_out got v=%b d=%h g=%0d exp 1/0ab/2", out_valid, out_data, grant_id);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] hold_d;
        logic [1:0]   hold_g;
        drive(4'b1111, rand_data(), 1'b1);
        hold_d = out_data;
        hold_g = grant_id;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, rand_data(), 1'b0);
            checks++;
            if (obs_ready !== 4'b0000) begin
                errors++; $display("FAIL stall_ready[%0d] got %b exp 0000", i, obs_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_d || grant_id !== hold_g) begin
                errors++; $display("FAIL stall_hold[%0d] got d=%h g=%0d exp d=%h g=%0d", i, out_data, grant_id, hold_d, hold_g);
            end
        end
        drive(4'b1111, rand_data(), 1'b1);
        checks++;
        if (grant_id !== hold_g + 2'd1 || out_data !== m_data) begin
            errors++; $display("FAIL stall_release got g=%0d exp %0d", grant_id, hold_g + 2'd1);
        end
    endtask

    task automatic test_pair();
        int seq[3] = '{1, 3, 1};
        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(4'b1010, rand_data(), 1'b1);
            checks++;
            if (grant_id !== 2'(seq[i]) || (obs_ready & 4'b0101) !== 4'b0000) begin
                errors++; $display("FAIL pair[%0d] got g=%0d rdy=%b exp g=%0d", i, grant_id, obs_ready, seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b0110, rand_data(), 1'b0);
        do_reset(4'b1111);
        checks++;
        if (out_valid !== 1'b0 || obs_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_mid got v=%b rdy=%b exp 0/0000", out_valid, obs_ready);
        end
        drive(4'b1111, rand_data(), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || grant_id !== 2'd0) begin
            errors++; $display("FAIL reset_mid_next got v=%b g=%0d exp 1/0", out_valid, grant_id);
        end
    endtask

    task automatic test_random();
        logic [W+1:0] e;
        do_reset(4'b0000);
        for (int i = 0; i < 600; i++) begin
            drive(4'($urandom_range(0, 15)), rand_data(), ($urandom_range(0, 3) != 0));
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d] got %b exp %b", i, obs_ready, exp_ready);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid[%0d] got %b exp %b", i, out_valid, m_valid);
            end
            if (acc) begin
                e = exp_q.pop_front();
                checks++;
                if ({grant_id, out_data} !== e) begin
                    errors++; $display("FAIL rand_pkt[%0d] got g=%0d d=%h exp g=%0d d=%h", i, grant_id, out_data, e[W+1:W], e[W-1:0]);
                end
            end else if (m_valid) begin
                checks++;
                if (grant_id !== m_grant || out_data !== m_data) begin
                    errors++; $display("FAIL rand_hold[%0d] got g=%0d exp g=%0d", i, grant_id, m_grant);
                end
            end
        end
    endtask

`ifdef OUTPUT_RR_SCHED_STATS_EN
    task automatic test_stats();
        do_reset(4'b0000);
        for (int i = 0; i < 10; i++) drive(4'b0001, rand_data(), 1'b1);
        for (int i = 0; i < 3; i++) drive(4'b1000, rand_data(), 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
                errors++; $display("FAIL stats_cnt[%0d] got %0d exp %0d", i, grant_cnt[i*16 +: 16], m_cnt[i]);
            end
        end
        checks++;
        if (m_cnt[0] != 10 || m_cnt[3] != 3 || grant_cnt[0 +: 16] !== 16'd10) begin
            errors++; $display("FAIL stats_fixed got c0=%0d c3=%0d exp 10/3", grant_cnt[0 +: 16], grant_cnt[48 +: 16]);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr_all();
        test_single();
        test_stall();
        test_pair();
        test_reset_mid();
        test_random();
`ifdef OUTPUT_RR_SCHED_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_rr_sched.md
OUTPUT_RR_SCHED -- requirements
Module: output_rr_sched

Interface
REQ-001 Parameter WIDTH_packet, default 57, packet width in bits.
REQ-002 Parameter NUM_IN, default 4, number of requesters; fixed at 4 for this revision.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  4  bit i set: requester i offers a packet.
REQ-006 in_data  input  4*WIDTH_packet  packet of requester i at bits [i*WIDTH_packet +: WIDTH_packet].
REQ-007 in_ready  output  4  bit i set: requester i's packet is accepted this cycle.
REQ-008 out_valid  output  1  out_data holds a packet.
REQ-009 out_data  output  WIDTH_packet  registered packet to the output port.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 grant_id  output  2  index of the requester whose packet is in out_data.

Function
REQ-012 Transfer on any channel SHALL occur only in a cycle where its valid and ready are both 1.
REQ-013 Output register is free when out_valid=0, or when out_valid=1 and out_ready=1; this is the same-cycle refill case.
REQ-014 When the register is free and any in_valid is set, exactly one in_ready bit SHALL be 1; otherwise in_ready SHALL be 4'b0000.
REQ-015 Winner: first set in_valid bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr is the last granted index.
REQ-016 in_ready SHALL depend combinationally on in_valid, ptr, out_valid and out_ready; it SHALL NOT depend on in_data.
REQ-017 On acceptance, on the next edge: out_data <= winner's packet, out_valid <= 1, grant_id <= winner, ptr <= winner.
REQ-018 Latency from input handshake to out_valid SHALL be exactly 1 cycle.
REQ-019 Throughput: one packet per cycle when out_ready is held at 1.
REQ-020 out_valid=1 and out_ready=0: out_data, out_valid and grant_id SHALL hold, and in_ready SHALL be 0.
REQ-021 out_valid=1, out_ready=1 and no in_valid set: out_valid SHALL fall to 0 on the next edge; ptr SHALL be unchanged.
REQ-022 Fairness: a requester with in_valid held SHALL be granted within 4 accepted packets.
REQ-023 A requester that deasserts in_valid before its grant SHALL lose its turn; the scheduler keeps no memory of the request.
REQ-024 ptr wraps from 3 to 0; arithmetic is 2-bit modulo 4.
REQ-025 FSM has two states. EMPTY (out_valid=0) goes to FULL on acceptance. FULL goes to EMPTY on out_ready with no acceptance. FULL stays FULL on stall or same-cycle refill.

Reset
REQ-026 While reset=1 at an edge: out_valid=0, out_data=0, grant_id=0, ptr=3, in_ready=0.
REQ-027 ptr=3 after reset SHALL give input 0 first priority.
REQ-028 Reset mid-packet SHALL discard the held packet; no handshake SHALL complete in a cycle where reset=1.

Configuration
REQ-029 Macro OUTPUT_RR_SCHED_STATS_EN SHALL add output grant_cnt (4*16 bits, counter i at [i*16 +: 16]).
REQ-030 With the macro defined: counter i increments on each acceptance from requester i, saturates at 16'hFFFF, and clears on reset.
REQ-031 Without the macro: the grant_cnt port and its counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-032 Reset, then in_valid=4'b1111 with out_ready=1 -> grant_id sequence 0,1,2,3,0; one packet per cycle; first out_valid one cycle after the first handshake.
REQ-033 Only input 2 valid with data 57'h0AB, out_ready=1 -> in_ready=4'b0100 that cycle; out_data=57'h0AB and grant_id=2 next cycle.
REQ-034 out_valid=1 and out_ready=0 for 5 cycles with all inputs valid -> out_data and grant_id stable and in_ready=0 throughout; first grant after release is ptr+1.
REQ-035 Inputs 1 and 3 valid, ptr=3 -> grant 1, then 3, then 1; inputs 0 and 2 are never granted.
REQ-036 Assert reset while out_valid=1 -> out_valid=0 next cycle; the next grant with all inputs valid is input 0.
REQ-037 With OUTPUT_RR_SCHED_STATS_EN: 10 packets from input 0 and 3 from input 3 -> grant_cnt counter 0 = 10, counter 3 = 3, others 0.
